// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM encoding and port indices.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int NUM_PORTS = 2;
    localparam int PORT_CPU  = 0;
    localparam int PORT_AUX  = 1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester/RAM bus of mem_arbiter; master = requesters plus RAM, slave = arbiter.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_PORTS-1:0]  REQ;
    logic [NUM_PORTS-1:0]  WE;
    logic [ADDR_WIDTH-1:0] ADDR0;
    logic [ADDR_WIDTH-1:0] ADDR1;
    logic [DATA_WIDTH-1:0] WDATA0;
    logic [DATA_WIDTH-1:0] WDATA1;
    logic [NUM_PORTS-1:0]  ACK;
    logic [DATA_WIDTH-1:0] RDATA0;
    logic [DATA_WIDTH-1:0] RDATA1;
    logic [NUM_PORTS-1:0]  GNT;
    logic [ADDR_WIDTH-1:0] RAM_ADDR;
    logic [DATA_WIDTH-1:0] RAM_DATA;
    logic                  RAM_WE;
    logic [DATA_WIDTH-1:0] RAM_Q;

    modport master (
        output REQ, WE, ADDR0, ADDR1, WDATA0, WDATA1, RAM_Q,
        input  ACK, RDATA0, RDATA1, GNT, RAM_ADDR, RAM_DATA, RAM_WE
    );

    modport slave (
        input  REQ, WE, ADDR0, ADDR1, WDATA0, WDATA1, RAM_Q,
        output ACK, RDATA0, RDATA1, GNT, RAM_ADDR, RAM_DATA, RAM_WE
    );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational 2-way winner select. Round-robin on ties by default;
// MEM_ARBITER_CPU_PRIORITY_EN makes the CPU port win every tie.
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
(
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic                 i_last,
    output logic [NUM_PORTS-1:0] o_win
);

`ifdef MEM_ARBITER_CPU_PRIORITY_EN
    logic w_last_unused;
    assign w_last_unused = i_last;

    always_comb begin
        o_win = '0;
        if (i_req[PORT_CPU])
            o_win[PORT_CPU] = 1'b1;
        else if (i_req[PORT_AUX])
            o_win[PORT_AUX] = 1'b1;
    end
`else
    // i_last is the index of the previous winner; a tie goes to the other port.
    always_comb begin
        o_win = '0;
        if (i_req[PORT_CPU] && i_req[PORT_AUX]) begin
            if (i_last)
                o_win[PORT_CPU] = 1'b1;
            else
                o_win[PORT_AUX] = 1'b1;
        end else begin
            o_win = i_req;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port REQ/ACK arbiter in front of a single-port synchronous RAM (1-cycle q latency).
// Tie policy is chosen in mem_arbiter_pick via MEM_ARBITER_CPU_PRIORITY_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8
) (
    input logic          CLK,
    input logic          RESET_n,
    mem_arbiter_if.slave bus
);

    // state    | meaning
    // ST_IDLE  | no owner; winner's command latched onto the RAM bus when any REQ
    // ST_ISSUE | RAM samples addr/data/we at the end of this cycle
    // ST_WAIT  | RAM_Q valid; read data captured, ACK raised for next cycle
    // ST_DONE  | ACK pulse to owner; REQ ignored; return to idle

    state_t                  r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_ram_addr, w_ram_addr_nxt;
    logic [DATA_WIDTH-1:0]   r_ram_data, w_ram_data_nxt;
    logic                    r_ram_we, w_ram_we_nxt;
    logic                    r_wr, w_wr_nxt;
    logic [NUM_PORTS-1:0]    r_gnt, w_gnt_nxt;
    logic [NUM_PORTS-1:0]    r_ack, w_ack_nxt;
    logic [DATA_WIDTH-1:0]   r_rdata0, w_rdata0_nxt;
    logic [DATA_WIDTH-1:0]   r_rdata1, w_rdata1_nxt;
    logic                    r_last, w_last_nxt;
    logic [NUM_PORTS-1:0]    w_win;

    mem_arbiter_pick u_pick (
        .i_req  (bus.REQ),
        .i_last (r_last),
        .o_win  (w_win)
    );

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state    <= ST_IDLE;
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_ram_we   <= 1'b0;
            r_wr       <= 1'b0;
            r_gnt      <= '0;
            r_ack      <= '0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_last     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_ram_addr <= w_ram_addr_nxt;
            r_ram_data <= w_ram_data_nxt;
            r_ram_we   <= w_ram_we_nxt;
            r_wr       <= w_wr_nxt;
            r_gnt      <= w_gnt_nxt;
            r_ack      <= w_ack_nxt;
            r_rdata0   <= w_rdata0_nxt;
            r_rdata1   <= w_rdata1_nxt;
            r_last     <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ram_addr_nxt = r_ram_addr;
        w_ram_data_nxt = r_ram_data;
        w_ram_we_nxt   = r_ram_we;
        w_wr_nxt       = r_wr;
        w_gnt_nxt      = r_gnt;
        w_ack_nxt      = r_ack;
        w_rdata0_nxt   = r_rdata0;
        w_rdata1_nxt   = r_rdata1;
        w_last_nxt     = r_last;

        case (r_state)
            ST_IDLE: begin
                w_ram_we_nxt = 1'b0;
                w_ack_nxt    = '0;
                if (|w_win) begin
                    if (w_win[PORT_AUX]) begin
                        w_ram_addr_nxt = bus.ADDR1;
                        w_ram_data_nxt = bus.WDATA1;
                        w_ram_we_nxt   = bus.WE[PORT_AUX];
                        w_wr_nxt       = bus.WE[PORT_AUX];
                    end else begin
                        w_ram_addr_nxt = bus.ADDR0;
                        w_ram_data_nxt = bus.WDATA0;
                        w_ram_we_nxt   = bus.WE[PORT_CPU];
                        w_wr_nxt       = bus.WE[PORT_CPU];
                    end
                    w_gnt_nxt   = w_win;
                    w_last_nxt  = w_win[PORT_AUX];
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_ram_we_nxt = 1'b0;
                w_state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                // The write strobe is already gone, so the latched r_wr decides.
                if (!r_wr) begin
                    if (r_gnt[PORT_AUX])
                        w_rdata1_nxt = bus.RAM_Q;
                    else
                        w_rdata0_nxt = bus.RAM_Q;
                end
                w_ack_nxt   = r_gnt;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_ack_nxt   = '0;
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.ACK      = r_ack;
    assign bus.GNT      = r_gnt;
    assign bus.RDATA0   = r_rdata0;
    assign bus.RDATA1   = r_rdata1;
    assign bus.RAM_ADDR = r_ram_addr;
    assign bus.RAM_DATA = r_ram_data;
    assign bus.RAM_WE   = r_ram_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural RAM, reference memory image and
// arbitration rules checked per scenario; honours MEM_ARBITER_CPU_PRIORITY_EN.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 13;
    localparam int DW = 8;
    localparam int MEM_WORDS = 1 << AW;

`ifdef MEM_ARBITER_CPU_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET_n = 1'b0;
    always #5 CLK = ~CLK;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .bus     (bus)
    );

    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [DW-1:0] d0 = '0, d1 = '0;

    assign bus.REQ    = {req1, req0};
    assign bus.WE     = {we1, we0};
    assign bus.ADDR0  = a0;
    assign bus.ADDR1  = a1;
    assign bus.WDATA0 = d0;
    assign bus.WDATA1 = d1;

    // behavioural single-port RAM, registered q, read-before-write
    logic [DW-1:0] ram [0:MEM_WORDS-1];
    logic [DW-1:0] ram_q = '0;
    assign bus.RAM_Q = ram_q;
    always @(posedge CLK) begin
        ram_q <= ram[bus.RAM_ADDR];
        if (bus.RAM_WE) ram[bus.RAM_ADDR] = bus.RAM_DATA;
    end

    // reference model: memory image and last read value per port
    logic [DW-1:0] ref_mem [0:MEM_WORDS-1];
    logic [DW-1:0] exp_rdata [2];

    int errors = 0;
    int checks = 0;
    bit done0, done1;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_port(input int p, input logic r, input logic w,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin req0 = r; we0 = w; a0 = a; d0 = d; end
        else        begin req1 = r; we1 = w; a1 = a; d1 = d; end
    endtask

    task automatic apply_reset();
        RESET_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_n = 1'b1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        @(negedge CLK);
    endtask

    // Drives one command and waits for its ACK; returns observations and model expectations.
    task automatic run_access(input int p, input logic w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input bit hold, input int limit,
                              output int lat, output int we_cyc, output logic [DW-1:0] rd,
                              output logic [DW-1:0] rd_exp, output bit tmo);
        drive_port(p, 1'b1, w, a, d);
        lat = 0; we_cyc = 0; tmo = 1'b1; rd = '0; rd_exp = '0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge CLK);
            if (bus.RAM_WE && bus.GNT[p]) we_cyc++;
            if (bus.ACK[p]) begin
                lat = k;
                tmo = 1'b0;
                rd = (p == 0) ? bus.RDATA0 : bus.RDATA1;
                if (w) ref_mem[a] = d;
                else   exp_rdata[p] = ref_mem[a];
                rd_exp = exp_rdata[p];
                break;
            end
        end
        if (!hold) drive_port(p, 1'b0, w, a, d);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        checks++;
        if ({bus.ACK, bus.GNT, bus.RAM_WE, bus.RAM_ADDR, bus.RAM_DATA, bus.RDATA0, bus.RDATA1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b gnt=%b we=%b addr=%h data=%h rd0=%h rd1=%h, all required 0",
                     bus.ACK, bus.GNT, bus.RAM_WE, bus.RAM_ADDR, bus.RAM_DATA, bus.RDATA0, bus.RDATA1);
        end
        RESET_n = 1'b1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        tick();
        drive_port(0, 1'b1, 1'b0, 13'h0010, 8'h00);
        repeat (3) @(negedge CLK);
        checks++;
        if (bus.GNT !== 2'b01) begin
            errors++;
            $display("FAIL wait_gnt: gnt=%b required 01", bus.GNT);
        end
        #1 RESET_n = 1'b0;
        #1;
        checks++;
        if ({bus.ACK, bus.GNT, bus.RAM_WE} !== 5'b0) begin
            errors++;
            $display("FAIL async_clear: ack=%b gnt=%b we=%b required 0", bus.ACK, bus.GNT, bus.RAM_WE);
        end
        req0 = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            checks++;
            if ({bus.ACK, bus.GNT, bus.RAM_WE, bus.RAM_ADDR, bus.RDATA0} !== '0) begin
                errors++;
                $display("FAIL post_reset_idle: ack=%b gnt=%b we=%b addr=%h rd0=%h required 0",
                         bus.ACK, bus.GNT, bus.RAM_WE, bus.RAM_ADDR, bus.RDATA0);
            end
        end
        begin
            int lat, wc; logic [DW-1:0] rd, rx; bit tmo;
            tick();
            run_access(0, 1'b0, 13'h0011, 8'h00, 1'b0, 20, lat, wc, rd, rx, tmo);
            checks++;
            if (tmo || lat != 4) begin
                errors++;
                $display("FAIL post_reset_latency: got %0d timeout=%0b required 4", lat, tmo);
            end
        end
    endtask

    task automatic test_single_read();
        int lat = 0;
        ram[13'h0123] = 8'hA5;
        ref_mem[13'h0123] = 8'hA5;
        tick();
        drive_port(0, 1'b1, 1'b0, 13'h0123, 8'h00);
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (k <= 4) begin
                checks++;
                if (bus.GNT !== ((k == 1) ? 2'b00 : 2'b01)) begin
                    errors++;
                    $display("FAIL read_gnt_cycle%0d: gnt=%b required %b", k, bus.GNT,
                             (k == 1) ? 2'b00 : 2'b01);
                end
            end
            if (bus.ACK[0]) begin lat = k; break; end
        end
        req0 = 1'b0;
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL read_latency: ack after %0d cycles required 4", lat);
        end
        checks++;
        if (bus.RDATA0 !== 8'hA5) begin
            errors++;
            $display("FAIL read_data: rdata0=%h required a5", bus.RDATA0);
        end
        exp_rdata[0] = 8'hA5;
        @(negedge CLK);
        checks++;
        if (bus.ACK !== 2'b00 || bus.GNT !== 2'b00) begin
            errors++;
            $display("FAIL ack_pulse: ack=%b gnt=%b one cycle after ack, required 00 00", bus.ACK, bus.GNT);
        end
    endtask

    task automatic test_write_read();
        int lat, wc; logic [DW-1:0] rd, rx; bit tmo;
        tick();
        run_access(1, 1'b1, 13'h1FFF, 8'h5A, 1'b1, 20, lat, wc, rd, rx, tmo);
        checks++;
        if (tmo || wc != 1) begin
            errors++;
            $display("FAIL write_we_pulse: ram_we high %0d cycles timeout=%0b required 1", wc, tmo);
        end
        checks++;
        if (rd !== rx) begin
            errors++;
            $display("FAIL write_rdata_hold: rdata1=%h required %h", rd, rx);
        end
        checks++;
        if (ram[13'h1FFF] !== 8'h5A) begin
            errors++;
            $display("FAIL write_mem: ram=%h required 5a", ram[13'h1FFF]);
        end
        run_access(1, 1'b0, 13'h1FFF, 8'h00, 1'b0, 20, lat, wc, rd, rx, tmo);
        checks++;
        if (tmo || rd !== 8'h5A || wc != 0) begin
            errors++;
            $display("FAIL readback: rdata1=%h we_cycles=%0d timeout=%0b required 5a 0 0", rd, wc, tmo);
        end
    endtask

    task automatic test_tie();
        int n_ack = 0, ack1 = 0, t_prev = 0;
        int t_port[2] = '{0, 0};
        apply_reset();
        tick();
        drive_port(0, 1'b1, 1'b0, AW'($urandom_range(0, MEM_WORDS - 1)), 8'h00);
        drive_port(1, 1'b1, 1'b0, AW'($urandom_range(0, MEM_WORDS - 1)), 8'h00);
        for (int k = 1; k <= 80 && n_ack < 8; k++) begin
            @(negedge CLK);
            if (bus.ACK[1]) ack1++;
            if (bus.ACK != 2'b00) begin
                int p, expp;
                logic [AW-1:0] a;
                logic [DW-1:0] rd;
                p = bus.ACK[1] ? 1 : 0;
                expp = PRIO ? 0 : (n_ack % 2);
                a = (p == 0) ? a0 : a1;
                rd = (p == 0) ? bus.RDATA0 : bus.RDATA1;
                checks++;
                if (bus.ACK === 2'b11 || p != expp) begin
                    errors++;
                    $display("FAIL tie_order%0d: ack=%b required port %0d", n_ack, bus.ACK, expp);
                end
                checks++;
                if (rd !== ref_mem[a]) begin
                    errors++;
                    $display("FAIL tie_data%0d: rdata=%h required %h", n_ack, rd, ref_mem[a]);
                end
                exp_rdata[p] = ref_mem[a];
                if (n_ack > 0) begin
                    checks++;
                    if (k - t_prev != 4) begin
                        errors++;
                        $display("FAIL tie_interval%0d: %0d cycles between acks required 4", n_ack, k - t_prev);
                    end
                end
                if (!PRIO && n_ack > 1) begin
                    checks++;
                    if (k - t_port[p] > 8) begin
                        errors++;
                        $display("FAIL tie_gap%0d: port %0d waited %0d cycles required <=8",
                                 n_ack, p, k - t_port[p]);
                    end
                end
                t_prev = k;
                t_port[p] = k;
                n_ack++;
                drive_port(p, 1'b1, 1'b0, AW'($urandom_range(0, MEM_WORDS - 1)), 8'h00);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        checks++;
        if (n_ack != 8) begin
            errors++;
            $display("FAIL tie_count: %0d acks required 8", n_ack);
        end
        if (PRIO) begin
            checks++;
            if (ack1 != 0) begin
                errors++;
                $display("FAIL prio_starve: ack[1] seen %0d times required 0", ack1);
            end
        end
    endtask

    task automatic test_mid_change();
        logic [DW-1:0] orig43;
        bit changed = 1'b0, acked = 1'b0;
        orig43 = ref_mem[13'h0043];
        tick();
        drive_port(0, 1'b1, 1'b1, 13'h0042, 8'h77);
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (bus.GNT[0] && !changed) begin
                checks++;
                if (bus.RAM_ADDR !== 13'h0042 || bus.RAM_DATA !== 8'h77 || bus.RAM_WE !== 1'b1) begin
                    errors++;
                    $display("FAIL issue_bus: addr=%h data=%h we=%b required 0042 77 1",
                             bus.RAM_ADDR, bus.RAM_DATA, bus.RAM_WE);
                end
                drive_port(0, 1'b0, 1'b1, 13'h0043, 8'h11);
                changed = 1'b1;
            end
            if (bus.ACK[0]) begin acked = 1'b1; break; end
        end
        checks++;
        if (!changed || !acked) begin
            errors++;
            $display("FAIL dropped_req_ack: granted=%0b acked=%0b required 1 1", changed, acked);
        end
        ref_mem[13'h0042] = 8'h77;
        checks++;
        if (ram[13'h0042] !== 8'h77 || ram[13'h0043] !== orig43) begin
            errors++;
            $display("FAIL latched_cmd: ram42=%h ram43=%h required 77 %h",
                     ram[13'h0042], ram[13'h0043], orig43);
        end
    endtask

    task automatic rand_driver(input int p);
        int lat, wc, gap; logic [DW-1:0] rd, rx; bit tmo, hold;
        for (int n = 0; n < 12; n++) begin
            if (PRIO && p == 0) begin
                hold = 1'b0;
                gap = $urandom_range(1, 3);
            end else begin
                hold = 1'($urandom_range(0, 1));
                gap = $urandom_range(0, 3);
            end
            if (n == 11) hold = 1'b0;
            run_access(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
                       hold, 64, lat, wc, rd, rx, tmo);
            checks++;
            if (tmo || rd !== rx) begin
                errors++;
                $display("FAIL rand_p%0d_%0d: rdata=%h timeout=%0b required %h", p, n, rd, tmo, rx);
            end
            if (!hold) repeat (gap) @(negedge CLK);
        end
        if (p == 0) done0 = 1'b1;
        else        done1 = 1'b1;
    endtask

    task automatic arb_monitor();
        logic [1:0] r, g, gp, expw;
        int wt[2] = '{0, 0};
        bit last_w = 1'b1;
        gp = 2'b00;
        while (!(done0 && done1)) begin
            @(posedge CLK);
            r = bus.REQ;
            @(negedge CLK);
            g = bus.GNT;
            for (int p = 0; p < 2; p++) begin
                if (!r[p]) wt[p] = 0;
                else if (!g[p]) wt[p]++;
            end
            if (g != 2'b00 && gp == 2'b00) begin
                if (r == 2'b11) expw = (PRIO || last_w) ? 2'b01 : 2'b10;
                else            expw = r;
                checks++;
                if (g !== expw) begin
                    errors++;
                    $display("FAIL rand_grant: req=%b gnt=%b required %b", r, g, expw);
                end
                last_w = g[1];
                if (!PRIO) begin
                    checks++;
                    if (wt[g[1]] > 8) begin
                        errors++;
                        $display("FAIL rand_wait: port %0d waited %0d cycles required <=8", g[1], wt[g[1]]);
                    end
                end
                wt[g[1]] = 0;
            end
            gp = g;
        end
    endtask

    task automatic test_random();
        apply_reset();
        done0 = 1'b0;
        done1 = 1'b0;
        fork
            rand_driver(0);
            rand_driver(1);
            arb_monitor();
        join
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            logic [DW-1:0] v;
            v = DW'($urandom);
            ram[i] = v;
            ref_mem[i] = v;
        end
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        test_reset();
        test_single_read();
        test_write_read();
        test_tie();
        test_mid_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
